// File: rtl/xg_soc.sv
// xg_soc: UART byte receiver driving an 8-bit display, with optional echo.
// Define SOC_ECHO_EN to build the TX echo path and its holding buffer.
module xg_soc #(
  parameter int FREQ_MHZ = 50,
  parameter int BAUDS    = 115200
) (
  input  logic       clk,
  input  logic       reset_i,
  output logic [7:0] display_o,
  input  logic       rx_i,
  output logic       tx_o
);

  localparam int CPB_RAW = (FREQ_MHZ * 1000000) / BAUDS;
  localparam int CPB     = (CPB_RAW < 2) ? 2 : CPB_RAW;
  localparam int CW      = $clog2(CPB) + 1;

  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic rx_s1;
  logic rx_s2;
  logic rx_d;

  // Two-flop synchronizer plus one delayed copy for edge detect.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  state_t        rx_st;
  state_t        rx_st_n;
  logic [CW-1:0] rx_cnt;
  logic [CW-1:0] rx_cnt_n;
  logic [2:0]    rx_bit;
  logic [2:0]    rx_bit_n;
  logic [7:0]    rx_sh;
  logic [7:0]    rx_sh_n;
  logic          rx_ok;

  // RX next state: mid-bit sampling timed from the start edge.
  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_ok    = 1'b0;
    unique case (rx_st)
      S_IDLE: begin
        if (rx_d && !rx_s2) begin
          rx_st_n  = S_START;
          rx_cnt_n = '0;
        end
      end
      S_START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_st_n  = rx_s2 ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_n = rx_cnt + ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7) begin
            rx_st_n = S_STOP;
          end
        end else begin
          rx_cnt_n = rx_cnt + ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          rx_st_n  = S_IDLE;
          rx_ok    = rx_s2;
        end else begin
          rx_cnt_n = rx_cnt + ONE;
        end
      end
      default: rx_st_n = S_IDLE;
    endcase
  end

  // RX state register; a good stop bit latches the byte to the display.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      rx_st     <= S_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      display_o <= 8'h00;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
      if (rx_ok) begin
        display_o <= rx_sh;
      end
    end
  end

`ifdef SOC_ECHO_EN
  logic          rx_vld;
  state_t        tx_st;
  state_t        tx_st_n;
  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] tx_cnt_n;
  logic [2:0]    tx_bit;
  logic [2:0]    tx_bit_n;
  logic [7:0]    tx_sh;
  logic [7:0]    tx_sh_n;
  logic          tx_q_n;
  logic          tx_free;
  logic          tx_load;
  logic [7:0]    tx_ld_d;
  logic          buf_full;
  logic          buf_full_n;
  logic [7:0]    buf_data;
  logic [7:0]    buf_data_n;

  // TX next state and holding-buffer arbitration.
  always_comb begin
    tx_st_n    = tx_st;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_q_n     = tx_o;
    tx_free    = 1'b0;
    tx_load    = 1'b0;
    tx_ld_d    = display_o;
    buf_full_n = buf_full;
    buf_data_n = buf_data;
    unique case (tx_st)
      S_IDLE: begin
        tx_free = 1'b1;
        tx_q_n  = 1'b1;
      end
      S_START: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          tx_bit_n = '0;
          tx_st_n  = S_DATA;
          tx_q_n   = tx_sh[0];
        end else begin
          tx_cnt_n = tx_cnt + ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          tx_sh_n  = {1'b1, tx_sh[7:1]};
          tx_bit_n = tx_bit + 3'd1;
          if (tx_bit == 3'd7) begin
            tx_st_n = S_STOP;
            tx_q_n  = 1'b1;
          end else begin
            tx_q_n = tx_sh[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          tx_st_n  = S_IDLE;
          tx_q_n   = 1'b1;
          tx_free  = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + ONE;
        end
      end
      default: tx_st_n = S_IDLE;
    endcase
    // Buffered byte goes first; a new byte then refills the freed slot.
    if (tx_free) begin
      if (buf_full) begin
        tx_load    = 1'b1;
        tx_ld_d    = buf_data;
        buf_full_n = rx_vld;
        if (rx_vld) begin
          buf_data_n = display_o;
        end
      end else if (rx_vld) begin
        tx_load = 1'b1;
      end
    end else if (rx_vld && !buf_full) begin
      buf_full_n = 1'b1;
      buf_data_n = display_o;
    end
    if (tx_load) begin
      tx_st_n  = S_START;
      tx_cnt_n = '0;
      tx_sh_n  = tx_ld_d;
      tx_q_n   = 1'b0;
    end
  end

  // TX state register; reset forces the line idle on the next edge.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      rx_vld   <= 1'b0;
      tx_st    <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_o     <= 1'b1;
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      rx_vld   <= rx_ok;
      tx_st    <= tx_st_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_o     <= tx_q_n;
      buf_full <= buf_full_n;
      buf_data <= buf_data_n;
    end
  end
`else
  assign tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_xg_soc.sv
// tb_xg_soc: directed UART stimulus with display and echo scoreboards.
// Runs at 1 MHz / 115200 baud, i.e. 8 clocks per bit.
module tb_xg_soc;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] display_o;
  logic       tx_o;

  xg_soc #(
    .FREQ_MHZ(1),
    .BAUDS(115200)
  ) dut (
    .clk(clk),
    .reset_i(reset_i),
    .display_o(display_o),
    .rx_i(rx_i),
    .tx_o(tx_o)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_disp[$];
  logic [7:0] exp_tx[$];
  bit         disp_mon_en = 1'b0;
  logic [7:0] disp_last = 8'h00;
  int         gen = 0;
  logic       tx_prev = 1'b1;

  task automatic check8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    rx_i = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_cyc(CPB);
    end
    rx_i = stopb;
    wait_cyc(CPB);
    rx_i = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    exp_disp.push_back(b);
`ifdef SOC_ECHO_EN
    exp_tx.push_back(b);
`endif
  endtask

  // Display scoreboard: every change must match the next expected byte.
  always @(negedge clk) begin
    if (disp_mon_en && display_o !== disp_last) begin
      n_cmp++;
      assert (exp_disp.size() != 0) else begin
        n_bad++;
        $error("FAIL disp_unexpected observed=%h expected=none", display_o);
      end
      if (exp_disp.size() != 0) begin
        n_cmp--;
        check8("disp_seq", display_o, exp_disp.pop_front());
      end
      disp_last = display_o;
    end
  end

  // Echo scoreboard: decode frames on tx_o at mid-bit points.
  always @(negedge clk) begin
    int         g;
    logic [7:0] b;
    logic       st;
    logic       sp;
    if (tx_prev === 1'b1 && tx_o === 1'b0) begin
      g = gen;
      repeat (CPB / 2 - 1) @(negedge clk);
      st = tx_o;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx_o;
      end
      repeat (CPB) @(negedge clk);
      sp = tx_o;
      if (g == gen) begin
        check8("tx_start_bit", {7'b0, st}, 8'h00);
        check8("tx_stop_bit", {7'b0, sp}, 8'h01);
        n_cmp++;
        assert (exp_tx.size() != 0) else begin
          n_bad++;
          $error("FAIL tx_unexpected observed=%h expected=none", b);
        end
        if (exp_tx.size() != 0) begin
          n_cmp--;
          check8("tx_echo", b, exp_tx.pop_front());
        end
      end
    end
    tx_prev = tx_o;
  end

  initial begin
    int bad_idle;

    reset_i = 1'b1;
    rx_i    = 1'b1;
    wait_cyc(2);
    check8("rst_display", display_o, 8'h00);
    check8("rst_tx", {7'b0, tx_o}, 8'h01);
    reset_i     = 1'b0;
    disp_last   = 8'h00;
    disp_mon_en = 1'b1;

    bad_idle = 0;
    repeat (10000) begin
      @(negedge clk);
      if (display_o !== 8'h00 || tx_o !== 1'b1) bad_idle++;
    end
    checki("idle_hold", bad_idle, 0);

    push(8'hA5);
    send_frame(8'hA5, 1'b1);
    check8("a5_within_80", display_o, 8'hA5);
    wait_cyc(100);

    send_frame(8'h3C, 1'b0);
    wait_cyc(20);
    check8("framing_keep", display_o, 8'hA5);
    wait_cyc(100);

    rx_i = 1'b0;
    wait_cyc(2);
    rx_i = 1'b1;
    wait_cyc(50);
    check8("glitch_keep", display_o, 8'hA5);

    push(8'h11);
    push(8'h22);
    push(8'h33);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    check8("b2b_last", display_o, 8'h33);
    wait_cyc(200);
    checki("b2b_echo_drained", exp_tx.size(), 0);

    rx_i = 1'b0;
    wait_cyc(CPB);
    rx_i = 1'b0;
    wait_cyc(CPB);
    rx_i = 1'b1;
    wait_cyc(CPB);
    rx_i = 1'b1;
    wait_cyc(CPB);
    rx_i = 1'b0;
    wait_cyc(CPB / 2);
    disp_mon_en = 1'b0;
    gen++;
    reset_i = 1'b1;
    wait_cyc(1);
    check8("rxrst_display", display_o, 8'h00);
    check8("rxrst_tx", {7'b0, tx_o}, 8'h01);
    wait_cyc(1);
    reset_i     = 1'b0;
    rx_i        = 1'b1;
    disp_last   = 8'h00;
    disp_mon_en = 1'b1;
    wait_cyc(20);

    push(8'h5A);
    send_frame(8'h5A, 1'b1);
    check8("rxrst_5a", display_o, 8'h5A);
    wait_cyc(100);

    push(8'hC3);
    send_frame(8'hC3, 1'b1);
    check8("c3_display", display_o, 8'hC3);
    wait_cyc(36);
`ifdef SOC_ECHO_EN
    check8("tx_bit3_low", {7'b0, tx_o}, 8'h00);
`endif
    disp_mon_en = 1'b0;
    gen++;
    exp_tx.delete();
    reset_i = 1'b1;
    wait_cyc(1);
    check8("txrst_tx", {7'b0, tx_o}, 8'h01);
    check8("txrst_display", display_o, 8'h00);
    wait_cyc(1);
    reset_i     = 1'b0;
    disp_last   = 8'h00;
    disp_mon_en = 1'b1;
    wait_cyc(20);

    push(8'h5A);
    send_frame(8'h5A, 1'b1);
    check8("txrst_5a", display_o, 8'h5A);
    wait_cyc(120);

    checki("disp_queue_empty", exp_disp.size(), 0);
    checki("tx_queue_empty", exp_tx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
